// File: rtl/free_list_pkg.sv
// Shared rename-path definitions for the physical-register free list.
// Packet typedefs are used for top-level wiring between dispatch, ROB and free list.
package free_list_pkg;

    localparam int PHYS_REGS     = 64;
    localparam int ARCH_REGS     = 32;
    localparam int PHYS_REG_BITS = $clog2(PHYS_REGS);
    localparam int FL_CNT_BITS   = $clog2(PHYS_REGS - ARCH_REGS + 1);

    typedef struct packed {
        logic [2:0]                    alloc_en;
        logic [2:0]                    free_valid;
        logic [2:0][PHYS_REG_BITS-1:0] free_tag_in;
    } fl_input;

    typedef struct packed {
        logic [2:0][PHYS_REG_BITS-1:0] free_tag;
        logic [2:0]                    avail;
        logic [FL_CNT_BITS-1:0]        free_count;
    } fl_output;

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/fl_ptr_inc.sv
// Modular pointer increment by 0..3 for a circular buffer of arbitrary size.
// Uses add-then-conditional-subtract, so FL_SZ need not be a power of two.
module fl_ptr_inc #(
    parameter int FL_SZ = 32,
    parameter int PTR_W = 5
) (
    input  logic [PTR_W-1:0] ptr_i,
    input  logic [1:0]       step_i,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W:0] sum;

    always_comb begin
        sum = {1'b0, ptr_i} + {{(PTR_W-1){1'b0}}, step_i};
        if (sum >= (PTR_W+1)'(FL_SZ)) begin
            ptr_o = PTR_W'(sum - (PTR_W+1)'(FL_SZ));
        end else begin
            ptr_o = sum[PTR_W-1:0];
        end
    end

endmodule

// File: rtl/free_list.sv
// Physical-register free list: circular FIFO of tags, 3-wide pop at head for rename,
// 3-wide compacting push at tail for tags reclaimed by ROB retirement.
module free_list
    import free_list_pkg::*;
#(
    parameter int PHYS_REGS = free_list_pkg::PHYS_REGS,
    parameter int ARCH_REGS = free_list_pkg::ARCH_REGS,
    parameter int FL_SZ     = PHYS_REGS - ARCH_REGS,
    localparam int TAG_W    = $clog2(PHYS_REGS),
    localparam int CNT_W    = $clog2(FL_SZ + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             alloc_en_1,
    input  logic             alloc_en_2,
    input  logic             alloc_en_3,
    input  logic             free_valid_1,
    input  logic             free_valid_2,
    input  logic             free_valid_3,
    input  logic [TAG_W-1:0] free_tag_in_1,
    input  logic [TAG_W-1:0] free_tag_in_2,
    input  logic [TAG_W-1:0] free_tag_in_3,
    output logic [TAG_W-1:0] free_tag_1,
    output logic [TAG_W-1:0] free_tag_2,
    output logic [TAG_W-1:0] free_tag_3,
    output logic             avail_1,
    output logic             avail_2,
    output logic             avail_3,
    output logic [CNT_W-1:0] free_count
);

    localparam int PTR_W = (FL_SZ > 4) ? $clog2(FL_SZ) : 2;

    logic [TAG_W-1:0] entry_q [FL_SZ];
    logic [TAG_W-1:0] entry_d [FL_SZ];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [2:0]       alloc_en, free_valid, avail;
    logic [TAG_W-1:0] free_tag_in [3];
    logic [1:0]       n_req, n_alloc, n_free, wr_off;
    logic [PTR_W-1:0] head_plus [3];
    logic [PTR_W-1:0] tail_plus [3];

    assign alloc_en       = {alloc_en_3, alloc_en_2, alloc_en_1};
    assign free_valid     = {free_valid_3, free_valid_2, free_valid_1};
    assign free_tag_in[0] = free_tag_in_1;
    assign free_tag_in[1] = free_tag_in_2;
    assign free_tag_in[2] = free_tag_in_3;

    assign n_req   = popcount3(alloc_en);
    assign n_free  = popcount3(free_valid);
    // Never pop past the occupied entries, even on an illegal request.
    assign n_alloc = (int'(n_req) > int'(count_q)) ? count_q[1:0] : n_req;

    assign head_plus[0] = head_q;
    assign tail_plus[0] = tail_q;

    for (genvar k = 1; k < 3; k++) begin : g_plus
        fl_ptr_inc #(.FL_SZ(FL_SZ), .PTR_W(PTR_W)) u_head_plus (
            .ptr_i (head_q),
            .step_i(2'(k)),
            .ptr_o (head_plus[k])
        );
        fl_ptr_inc #(.FL_SZ(FL_SZ), .PTR_W(PTR_W)) u_tail_plus (
            .ptr_i (tail_q),
            .step_i(2'(k)),
            .ptr_o (tail_plus[k])
        );
    end

    fl_ptr_inc #(.FL_SZ(FL_SZ), .PTR_W(PTR_W)) u_head_inc (
        .ptr_i (head_q),
        .step_i(n_alloc),
        .ptr_o (head_d)
    );

    fl_ptr_inc #(.FL_SZ(FL_SZ), .PTR_W(PTR_W)) u_tail_inc (
        .ptr_i (tail_q),
        .step_i(n_free),
        .ptr_o (tail_d)
    );

    // Valid retiring tags are packed in slot order into tail, tail+1, tail+2.
    always_comb begin
        entry_d = entry_q;
        wr_off  = 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (free_valid[k]) begin
                entry_d[tail_plus[wr_off]] = free_tag_in[k];
                wr_off = wr_off + 2'd1;
            end
        end
        count_d = CNT_W'(int'(count_q) - int'(n_alloc) + int'(n_free));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FL_SZ; i++) begin
                entry_q[i] <= TAG_W'(ARCH_REGS + i);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CNT_W'(FL_SZ);
        end else begin
            entry_q <= entry_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign free_tag_1 = entry_q[head_plus[0]];
    assign free_tag_2 = entry_q[head_plus[1]];
    assign free_tag_3 = entry_q[head_plus[2]];
    assign avail[0]   = (int'(count_q) >= 1);
    assign avail[1]   = (int'(count_q) >= 2);
    assign avail[2]   = (int'(count_q) >= 3);
    assign avail_1    = avail[0];
    assign avail_2    = avail[1];
    assign avail_3    = avail[2];
    assign free_count = count_q;

    // A freed tag must not already sit in the occupied window or repeat within the group.
    logic dup_free;

    always_comb begin
        dup_free = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (free_valid[k]) begin
                for (int i = 0; i < FL_SZ; i++) begin
                    if ((((i - int'(head_q)) + FL_SZ) % FL_SZ) < int'(count_q) &&
                        entry_q[i] == free_tag_in[k]) begin
                        dup_free = 1'b1;
                    end
                end
                for (int j = 0; j < k; j++) begin
                    if (free_valid[j] && free_tag_in[j] == free_tag_in[k]) begin
                        dup_free = 1'b1;
                    end
                end
            end
        end
    end

    a_alloc_prefix: assert property (@(posedge clock) disable iff (reset)
        alloc_en inside {3'b000, 3'b001, 3'b011, 3'b111});

    a_alloc_avail: assert property (@(posedge clock) disable iff (reset)
        (alloc_en & ~avail) == 3'b000);

    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        (int'(count_q) - int'(n_alloc) + int'(n_free)) <= FL_SZ);

    a_no_dup: assert property (@(posedge clock) disable iff (reset)
        !dup_free);

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: a 64-register instance for reset/drain/refill/sparse free,
// and a 39-register instance (7-entry list) for wrap-around, mixed traffic and mid-stream reset.
module tb_free_list;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic       rst64, rst39;
    logic [2:0] a64, v64, a39, v39;
    logic [5:0] t64 [3];
    logic [5:0] t39 [3];
    logic [5:0] ft64 [3];
    logic [5:0] ft39 [3];
    logic [2:0] av64, av39;
    logic [5:0] cnt64;
    logic [2:0] cnt39;

    free_list #(.PHYS_REGS(64), .ARCH_REGS(32)) dut64 (
        .clock(clock), .reset(rst64),
        .alloc_en_1(a64[0]), .alloc_en_2(a64[1]), .alloc_en_3(a64[2]),
        .free_valid_1(v64[0]), .free_valid_2(v64[1]), .free_valid_3(v64[2]),
        .free_tag_in_1(t64[0]), .free_tag_in_2(t64[1]), .free_tag_in_3(t64[2]),
        .free_tag_1(ft64[0]), .free_tag_2(ft64[1]), .free_tag_3(ft64[2]),
        .avail_1(av64[0]), .avail_2(av64[1]), .avail_3(av64[2]),
        .free_count(cnt64)
    );

    free_list #(.PHYS_REGS(39), .ARCH_REGS(32)) dut39 (
        .clock(clock), .reset(rst39),
        .alloc_en_1(a39[0]), .alloc_en_2(a39[1]), .alloc_en_3(a39[2]),
        .free_valid_1(v39[0]), .free_valid_2(v39[1]), .free_valid_3(v39[2]),
        .free_tag_in_1(t39[0]), .free_tag_in_2(t39[1]), .free_tag_in_3(t39[2]),
        .free_tag_1(ft39[0]), .free_tag_2(ft39[1]), .free_tag_3(ft39[2]),
        .avail_1(av39[0]), .avail_2(av39[1]), .avail_3(av39[2]),
        .free_count(cnt39)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    int flq[$];
    int outq[$];
    int got[3];
    int freed[3];
    int na, nf, lim;

    initial begin
        rst64 = 1'b1; rst39 = 1'b1;
        a64 = 3'b000; v64 = 3'b000; a39 = 3'b000; v39 = 3'b000;
        for (int k = 0; k < 3; k++) begin
            t64[k] = 6'd0;
            t39[k] = 6'd0;
        end
        tick();
        tick();
        rst64 = 1'b0; rst39 = 1'b0;

        chk("rst64_tag1", 32'(ft64[0]), 32);
        chk("rst64_tag2", 32'(ft64[1]), 33);
        chk("rst64_tag3", 32'(ft64[2]), 34);
        chk("rst64_avail", 32'(av64), 32'b111);
        chk("rst64_count", 32'(cnt64), 32);
        chk("rst39_tag1", 32'(ft39[0]), 32);
        chk("rst39_count", 32'(cnt39), 7);

        // Drain the 32-entry list: 10 x 3, then 2.
        a64 = 3'b111;
        for (int k = 0; k < 10; k++) begin
            chk("drain_tag1", 32'(ft64[0]), 32'(32 + 3 * k));
            chk("drain_count", 32'(cnt64), 32'(32 - 3 * k));
            tick();
        end
        a64 = 3'b011;
        chk("drain_last_tag1", 32'(ft64[0]), 62);
        chk("drain_last_tag2", 32'(ft64[1]), 63);
        chk("drain_last_avail", 32'(av64), 32'b011);
        chk("drain_last_count", 32'(cnt64), 2);
        tick();
        a64 = 3'b000;
        chk("empty_count", 32'(cnt64), 0);
        chk("empty_avail", 32'(av64), 32'b000);

        // Refill from empty: no same-cycle bypass.
        v64 = 3'b111; t64[0] = 6'd5; t64[1] = 6'd9; t64[2] = 6'd7;
        #1;
        chk("refill_no_bypass_avail", 32'(av64), 32'b000);
        tick();
        v64 = 3'b000;
        chk("refill_tag1", 32'(ft64[0]), 5);
        chk("refill_tag2", 32'(ft64[1]), 9);
        chk("refill_tag3", 32'(ft64[2]), 7);
        chk("refill_count", 32'(cnt64), 3);
        chk("refill_avail", 32'(av64), 32'b111);

        // Sparse free 101: slot 2 carries a junk tag that must not land.
        v64 = 3'b101; t64[0] = 6'd12; t64[1] = 6'd33; t64[2] = 6'd20;
        tick();
        v64 = 3'b000;
        chk("sparse_count", 32'(cnt64), 5);
        chk("sparse_head_kept", 32'(ft64[0]), 5);
        a64 = 3'b111;
        tick();
        a64 = 3'b000;
        chk("sparse_tag1", 32'(ft64[0]), 12);
        chk("sparse_tag2", 32'(ft64[1]), 20);
        chk("sparse_count_after", 32'(cnt64), 2);
        chk("sparse_avail_after", 32'(av64), 32'b011);

        // 7-entry list: alloc 3 + free 3 every cycle against a queue model.
        for (int i = 0; i < 7; i++) flq.push_back(32 + i);
        outq = '{0, 1, 2};
        for (int c = 0; c < 40; c++) begin
            a39 = 3'b111; v39 = 3'b111;
            for (int k = 0; k < 3; k++) begin
                freed[k] = outq[k];
                t39[k] = 6'(outq[k]);
            end
            chk("simul_tag1", 32'(ft39[0]), 32'(flq[0]));
            chk("simul_tag2", 32'(ft39[1]), 32'(flq[1]));
            chk("simul_tag3", 32'(ft39[2]), 32'(flq[2]));
            chk("simul_count", 32'(cnt39), 7);
            tick();
            for (int k = 0; k < 3; k++) begin
                got[k] = flq.pop_front();
                void'(outq.pop_front());
            end
            for (int k = 0; k < 3; k++) begin
                flq.push_back(freed[k]);
                outq.push_back(got[k]);
            end
        end

        // Mixed legal traffic on the 7-entry list.
        for (int c = 0; c < 30; c++) begin
            lim = (flq.size() < 3) ? flq.size() : 3;
            na = $urandom_range(lim, 0);
            lim = 3;
            if (outq.size() < lim) lim = outq.size();
            if (7 - flq.size() + na < lim) lim = 7 - flq.size() + na;
            nf = $urandom_range(lim, 0);
            a39 = 3'((1 << na) - 1);
            v39 = 3'((1 << nf) - 1);
            for (int k = 0; k < 3; k++) begin
                freed[k] = (k < nf) ? outq[k] : 0;
                t39[k] = 6'(freed[k]);
            end
            chk("mixed_count", 32'(cnt39), 32'(flq.size()));
            if (flq.size() > 0) chk("mixed_tag1", 32'(ft39[0]), 32'(flq[0]));
            tick();
            for (int k = 0; k < na; k++) got[k] = flq.pop_front();
            for (int k = 0; k < nf; k++) begin
                void'(outq.pop_front());
                flq.push_back(freed[k]);
            end
            for (int k = 0; k < na; k++) outq.push_back(got[k]);
        end

        // Reset mid-stream with a pending free on the inputs.
        rst39 = 1'b1; a39 = 3'b000; v39 = 3'b111;
        t39[0] = 6'd1; t39[1] = 6'd2; t39[2] = 6'd3;
        tick();
        rst39 = 1'b0; v39 = 3'b000;
        chk("midrst_tag1", 32'(ft39[0]), 32);
        chk("midrst_tag2", 32'(ft39[1]), 33);
        chk("midrst_count", 32'(cnt39), 7);
        chk("midrst_avail", 32'(av39), 32'b111);
        tick();
        chk("midrst_count_hold", 32'(cnt39), 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
